// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - memory-mapped port, input change detect and down-counter timer responder
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0100,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [7:0]            PortIn,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Hit,
  output logic [DATA_WIDTH-1:0] PortOut,
  output logic                  Irq
);

  // Word offsets inside the 32-byte window (Address[4:2]).
  localparam logic [2:0] OFF_PORT_OUT    = 3'd0;
  localparam logic [2:0] OFF_PORT_IN     = 3'd1;
  localparam logic [2:0] OFF_STATUS      = 3'd2;
  localparam logic [2:0] OFF_TIMER_LOAD  = 3'd3;
  localparam logic [2:0] OFF_TIMER_COUNT = 3'd4;
  localparam logic [2:0] OFF_CTRL        = 3'd5;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  // Timer is running only while enabled with a non-zero count.
  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

  logic [DATA_WIDTH-1:0] port_out_q, port_out_d;
  logic [DATA_WIDTH-1:0] timer_load_q, timer_load_d;
  logic [DATA_WIDTH-1:0] timer_count_q, timer_count_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic                  in_changed_q, in_changed_d;
  logic                  tmr_expired_q, tmr_expired_d;
  logic [7:0]            s1_q, in_sync_q, in_prev_q;

  logic [2:0]  off;
  logic        wr;
  logic        wr_port_out, wr_status, wr_timer_load, wr_ctrl;
  logic        tmr_en, auto_reload, irq_en_in, irq_en_tmr;
  logic        expire_evt;
  tmr_state_e  tmr_state;

  // MemRead has no side effects and byte lanes are ignored (word access only).
  logic        unused_bits;
  assign unused_bits = ^{MemRead, Address[1:0]};

  assign off = Address[4:2];
  assign Hit = (Address[31:5] == BASE_ADDR[31:5]);
  assign wr  = MemWrite & Hit;

  assign wr_port_out   = wr && (off == OFF_PORT_OUT);
  assign wr_status     = wr && (off == OFF_STATUS);
  assign wr_timer_load = wr && (off == OFF_TIMER_LOAD);
  assign wr_ctrl       = wr && (off == OFF_CTRL);

  assign tmr_en      = ctrl_q[0];
  assign auto_reload = ctrl_q[1];
  assign irq_en_in   = ctrl_q[2];
  assign irq_en_tmr  = ctrl_q[3];

  assign tmr_state = (tmr_en && (timer_count_q != '0)) ? TMR_RUN : TMR_IDLE;

  // State registers, including the PortIn synchronizer and change-detect flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q    <= '0;
      timer_load_q  <= '0;
      timer_count_q <= '0;
      ctrl_q        <= '0;
      in_changed_q  <= 1'b0;
      tmr_expired_q <= 1'b0;
      s1_q          <= '0;
      in_sync_q     <= '0;
      in_prev_q     <= '0;
    end else begin
      port_out_q    <= port_out_d;
      timer_load_q  <= timer_load_d;
      timer_count_q <= timer_count_d;
      ctrl_q        <= ctrl_d;
      in_changed_q  <= in_changed_d;
      tmr_expired_q <= tmr_expired_d;
      s1_q          <= PortIn;
      in_sync_q     <= s1_q;
      in_prev_q     <= in_sync_q;
    end
  end

  // Next-state logic: register writes, timer stepping, and sticky W1C flags.
  always_comb begin
    port_out_d    = port_out_q;
    timer_load_d  = timer_load_q;
    timer_count_d = timer_count_q;
    ctrl_d        = ctrl_q;
    expire_evt    = 1'b0;

    if (wr_port_out) begin
      port_out_d = WriteData;
    end
    if (wr_ctrl) begin
      ctrl_d = WriteData[3:0];
    end

    // A load overrides any decrement or expiry on the same edge.
    if (wr_timer_load) begin
      timer_load_d  = WriteData;
      timer_count_d = WriteData;
    end else begin
      case (tmr_state)
        TMR_RUN: begin
          if (timer_count_q == ONE) begin
            expire_evt = 1'b1;
            if (auto_reload && (timer_load_q != '0)) begin
              timer_count_d = timer_load_q;
            end else begin
              timer_count_d = '0;
            end
          end else begin
            timer_count_d = timer_count_q - ONE;
          end
        end
        default: timer_count_d = timer_count_q;
      endcase
    end

    // Set events win over a same-edge write-one-to-clear.
    in_changed_d  = (in_sync_q != in_prev_q) |
                    (in_changed_q & ~(wr_status & WriteData[0]));
    tmr_expired_d = expire_evt |
                    (tmr_expired_q & ~(wr_status & WriteData[1]));
  end

  // Combinational read mux; unmapped offsets and misses read as zero.
  always_comb begin
    ReadData = '0;
    if (Hit) begin
      case (off)
        OFF_PORT_OUT:    ReadData = port_out_q;
        OFF_PORT_IN:     ReadData = {{(DATA_WIDTH-8){1'b0}}, in_sync_q};
        OFF_STATUS:      ReadData = {{(DATA_WIDTH-2){1'b0}}, tmr_expired_q, in_changed_q};
        OFF_TIMER_LOAD:  ReadData = timer_load_q;
        OFF_TIMER_COUNT: ReadData = timer_count_q;
        OFF_CTRL:        ReadData = {{(DATA_WIDTH-4){1'b0}}, ctrl_q};
        default:         ReadData = '0;
      endcase
    end
  end

  assign PortOut = port_out_q;
  assign Irq     = (in_changed_q & irq_en_in) | (tmr_expired_q & irq_en_tmr);

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus: Address, WriteData, MemWrite, MemRead.
- Sits beside DataMemory. It decodes its own address window and drives the processor's PortOut register.
- Samples PortIn through a synchronizer and detects changes on it.
- Contains a programmable down-counter timer and raises an interrupt request.
- The top level selects ReadData from this block whenever Hit=1.

Parameters:
- BASE_ADDR, 32'h1001_0100, byte base of the 32-byte register window; must be 32-byte aligned.
- DATA_WIDTH, 32, bus data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset is asynchronous and active-low.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data (rt value).
- MemWrite  input  1  store strobe, sampled on the clk edge.
- MemRead  input  1  load strobe.
- PortIn  input  8  external asynchronous input pins.
- ReadData  output  32  combinational read data for the addressed register; 0 when Hit=0.
- Hit  output  1  Address[31:5]==BASE_ADDR[31:5].
- PortOut  output  32  PORT_OUT register value.
- Irq  output  1  interrupt request, level.

Behaviour:
- Decode:
  - Register select is off = Address[4:2]. Address[1:0] is ignored; word access only.
  - A write occurs on a clk edge with MemWrite & Hit. Read data is valid in the same cycle, because the processor is single-cycle.
- Register map (offset: name, access):
  - 0x00 PORT_OUT: RW, 32 bits.
  - 0x04 PORT_IN: RO, reads {24'b0, in_sync}.
  - 0x08 STATUS: W1C. bit0 in_changed, bit1 tmr_expired; other bits read 0.
  - 0x0C TIMER_LOAD: RW.
  - 0x10 TIMER_COUNT: RO.
  - 0x14 CTRL: RW, bits[3:0]. bit0 tmr_en, bit1 auto_reload, bit2 irq_en_in, bit3 irq_en_tmr.
  - 0x18, 0x1C: read 0, writes ignored.
  - Writes to RO registers are ignored.
- Reset (reset=0, asynchronous):
  - PORT_OUT, TIMER_LOAD, TIMER_COUNT, CTRL and STATUS all go to 0.
  - Synchronizer flops and the previous-sample flop go to 0.
  - Resulting outputs: PortOut=0, Irq=0. ReadData follows the cleared registers.
  - Reset asserted mid-count aborts the timer; no expiry is flagged.
- Input path:
  - PortIn passes through two flops (s1 then in_sync), then into a third flop, in_prev.
  - in_changed is set on any edge where in_sync != in_prev.
  - Latency: a PortIn change shows in PORT_IN after the 2nd clk edge; in_changed is set on the 3rd edge.
- STATUS clearing:
  - A STATUS write clears each flag whose WriteData bit is 1.
  - If a set event and a W1C hit the same flag on the same edge, the set wins and the flag stays 1.
- Timer state machine:
  - IDLE: TIMER_COUNT==0 or tmr_en==0. The count holds.
  - RUN: tmr_en==1 and TIMER_COUNT!=0. The count decrements by 1 every edge.
  - When RUN decrements from 1:
    - tmr_expired is set.
    - If auto_reload==1 and TIMER_LOAD!=0, TIMER_COUNT is reloaded with TIMER_LOAD and stays in RUN.
    - Otherwise TIMER_COUNT becomes 0 and goes to IDLE.
  - Clearing tmr_en in RUN freezes the count. Setting it again resumes from the frozen value.
  - Loading: a write to TIMER_LOAD loads both TIMER_LOAD and TIMER_COUNT with WriteData.
  - Load priority: the load takes priority over a same-cycle decrement or expiry, and no expiry is flagged on that edge.
  - Writing 0 to TIMER_LOAD stops the timer.
- Arithmetic: plain 32-bit unsigned decrement. TIMER_COUNT never wraps below 0.
- Irq = (in_changed & irq_en_in) | (tmr_expired & irq_en_tmr). Irq is combinational from registered state.
- MemRead has no side effects; reads are non-destructive.
- When Hit=0, no register changes except the free-running input path and timer.

Test Plan:
- Reset, then read every offset 0x00–0x1C at BASE_ADDR+off. Required: ReadData=0 each time; PortOut=0; Irq=0. With Address=0x1001_0000: Hit=0 and ReadData=0.
- Write 0xDEAD_BEEF to 0x1001_0100. Required: PortOut=0xDEAD_BEEF after that edge, and a read returns it. Write 0x1234 to 0x1001_0104 (RO). Required: PORT_IN unchanged.
- Enable input interrupts by writing CTRL=0x4, then drive PortIn 0x00→0xA5. Required: PORT_IN reads 0x0000_00A5 after 2 edges; STATUS=0x1 and Irq=1 after 3 edges. Write STATUS=0x1. Required: STATUS=0 and Irq=0.
- Write CTRL=0x9, then TIMER_LOAD=3. Required: TIMER_COUNT reads 3, 2, 1, 0 on successive cycles; STATUS bit1=1 and Irq=1 on the edge where the count hits 0; the count then stays 0.
- Write CTRL=0xB, then TIMER_LOAD=2. Required: the count sequence is 2, 1, 2, 1, …, and tmr_expired is set every 2 cycles. Issue a W1C on the same edge as an expiry. Required: bit1 stays 1.
- Reset pulse while the count is 5 with tmr_en=1. Required: all registers are 0 immediately, without waiting for a clk edge. After release, the timer stays IDLE.
